// File: rtl/bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_converter
//
// Iterative binary-to-packed-BCD converter (double dabble, one input bit per
// clock) for the 8-digit seven-segment display path. A value is accepted
// through a valid/ready handshake; WIDTH cycles later the 8 BCD digits appear
// on val_out together with a one-cycle done_out pulse. Values of 100,000,000
// and above saturate to 99999999 and raise ovf_out.
//
// Optional feature: define BCD_HEX_BYPASS_EN to add the hex_in port. An accept
// with hex_in=1 skips conversion and presents the zero-extended raw value one
// cycle later, so the display shows it in hexadecimal.
//
// Parameters:
//   WIDTH      binary input width, 1..27
//
// Ports:
//   clk_in     system clock, rising edge
//   rst_in     asynchronous active-low reset
//   data_in    unsigned binary value, sampled on accept
//   valid_in   source has a value to convert
//   hex_in     (BCD_HEX_BYPASS_EN only) bypass conversion for this accept
//   ready_out  high when idle; accept = valid_in && ready_out at a rising edge
//   val_out    packed BCD result, digit 0 in [3:0]; holds the last result
//   done_out   one-cycle pulse, val_out updated on the same edge
//   ovf_out    last accepted value did not fit in 8 digits
// -----------------------------------------------------------------------------
module bin_to_bcd_converter #(
    parameter int WIDTH = 27
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
`ifdef BCD_HEX_BYPASS_EN
    input  logic             hex_in,
`endif
    output logic             ready_out,
    output logic [31:0]      val_out,
    output logic             done_out,
    output logic             ovf_out
);

    localparam int          CW        = $clog2(WIDTH + 1);
    localparam logic [31:0] OVF_LIMIT = 32'd100_000_000;
    localparam logic [31:0] SAT_VAL   = 32'h9999_9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HEX   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [31:0]      bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      val_q, val_d;
    logic             done_q, done_d;
    logic             ovf_out_q, ovf_out_d;

    logic             accept;
    logic             hex_sel;
    logic [31:0]      adj;
    logic [31:0]      shifted;
    logic             saturate;

`ifdef BCD_HEX_BYPASS_EN
    assign hex_sel = hex_in;
`else
    assign hex_sel = 1'b0;
`endif

    // Ready is a pure state decode so valid_in has no combinational path out.
    assign ready_out = (state_q == ST_IDLE);
    assign accept    = valid_in && ready_out;

    // Add-3 correction: any digit >= 5 would become >= 10 after the doubling
    // shift, so pre-bias it to carry correctly into the next digit.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {adj[30:0], bin_q[WIDTH-1]};

    // A bit leaving the top of the working register implies the value needed
    // a ninth digit, which only happens when ovf_q is already set; folding it
    // in keeps the saturation decision self-consistent.
    assign saturate = ovf_q | adj[31];

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        val_d     = val_q;
        ovf_out_d = ovf_out_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bin_d = data_in;
                    if (hex_sel) begin
                        state_d = ST_HEX;
                    end else begin
                        state_d = ST_SHIFT;
                        bcd_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        ovf_d   = (32'(data_in) >= OVF_LIMIT);
                    end
                end
            end

            ST_SHIFT: begin
                bcd_d = shifted;
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = ST_IDLE;
                    val_d     = saturate ? SAT_VAL : shifted;
                    ovf_out_d = ovf_q;
                    done_d    = 1'b1;
                end
            end

            ST_HEX: begin
                state_d   = ST_IDLE;
                val_d     = 32'(bin_q);
                ovf_out_d = 1'b0;
                done_d    = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            val_q     <= '0;
            done_q    <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            val_q     <= val_d;
            done_q    <= done_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign val_out  = val_q;
    assign done_out = done_q;
    assign ovf_out  = ovf_out_q;

endmodule
